// File: rtl/avg_pkg.sv
// Shared definitions for the sounder RX averager run controller.
// State encoding and averager pipeline/flush timing constants.
package avg_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Averager pipeline depth; DRAIN waits this many enabled cycles.
  localparam int AVG_PIPE_DEPTH = 3;
  localparam int FLUSH_CYCLES   = 2;

endpackage

// File: rtl/avg_pos_cnt.sv
// L/M position counter: sample index within a period and period index within
// an average, with wrap flags. Shared with the averager datapath.
module avg_pos_cnt #(
  parameter int AWIDTH = 10,
  parameter int MWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [AWIDTH-1:0] l_max,
  input  logic [MWIDTH-1:0] m_max,
  output logic              l_wrap,
  output logic              m_wrap
);

  logic [AWIDTH-1:0] l_cnt;
  logic [MWIDTH-1:0] m_cnt;

  assign l_wrap = (l_cnt == l_max);
  assign m_wrap = (m_cnt == m_max);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      l_cnt <= '0;
      m_cnt <= '0;
    end else if (adv) begin
      if (l_wrap) begin
        l_cnt <= '0;
        m_cnt <= m_wrap ? '0 : m_cnt + 1'b1;
      end else begin
        l_cnt <= l_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/avg_sched.sv
// avg_sched: run controller for the sounder RX block averager. Latches config,
// flushes the averager, gates RX samples and stops only on round boundaries.
module avg_sched
  import avg_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int MWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] cfg_l,
  input  logic [MWIDTH-1:0] cfg_m,
  input  logic [3:0]        cfg_k,
  input  logic [CWIDTH-1:0] cfg_n,
  input  logic              cfg_trig_en,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              trig,
  input  logic              s_valid,
  input  logic              dn_ready,
  output logic              avg_rst,
  output logic              avg_en,
  output logic              avg_vin,
  output logic [AWIDTH-1:0] avg_l,
  output logic [MWIDTH-1:0] avg_m,
  output logic [3:0]        avg_k,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              ovf,
  output logic [CWIDTH-1:0] avg_cnt
);

  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(AVG_PIPE_DEPTH - 1);

  state_t            state, state_nxt;
  logic [1:0]        flush_cnt, drain_cnt;
  logic              stop_pend, trig_en_q, en_ok;
  logic [CWIDTH-1:0] n_q, cnt_inc;
  logic [AWIDTH-1:0] l_max;
  logic [MWIDTH-1:0] m_max;
  logic              l_wrap, m_wrap;
  logic              start_ok, start_bad, finish, round_done, last_avg;

  // en_ok keeps avg_en low for the cycle following reset.
  assign avg_en  = en_ok & (((state == S_IDLE) || (state == S_FLUSH)) ? 1'b1 : dn_ready);
  assign avg_vin = (state == S_RUN) & s_valid & dn_ready;

  assign l_max      = avg_l - 1'b1;
  assign m_max      = avg_m - 1'b1;
  assign cnt_inc    = avg_cnt + 1'b1;
  assign round_done = avg_vin & l_wrap & m_wrap;
  assign last_avg   = (n_q != '0) && (cnt_inc == n_q);

  avg_pos_cnt #(
    .AWIDTH(AWIDTH),
    .MWIDTH(MWIDTH)
  ) u_pos (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == S_FLUSH),
    .adv   (avg_vin),
    .l_max (l_max),
    .m_max (m_max),
    .l_wrap(l_wrap),
    .m_wrap(m_wrap)
  );

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_start) begin
          if ((cfg_l != '0) && (cfg_m != '0)) begin
            start_ok  = 1'b1;
            state_nxt = S_FLUSH;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt == FLUSH_LAST) state_nxt = S_ARM;
      end
      S_ARM: begin
        // Stop takes priority over a coincident trigger.
        if (cmd_stop)                 state_nxt = S_IDLE;
        else if (!trig_en_q || trig)  state_nxt = S_RUN;
      end
      S_RUN: begin
        if (round_done && (stop_pend || cmd_stop || last_avg)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (dn_ready && (drain_cnt == DRAIN_LAST)) begin
          state_nxt = S_IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      flush_cnt <= '0;
      drain_cnt <= '0;
      stop_pend <= 1'b0;
      trig_en_q <= 1'b0;
      en_ok     <= 1'b0;
      n_q       <= '0;
      avg_rst   <= 1'b1;
      avg_l     <= '0;
      avg_m     <= '0;
      avg_k     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      ovf       <= 1'b0;
      avg_cnt   <= '0;
    end else begin
      en_ok     <= 1'b1;
      state     <= state_nxt;
      avg_rst   <= (state_nxt == S_FLUSH);
      busy      <= (state_nxt != S_IDLE);
      done      <= finish;
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + 1'b1 : '0;
      drain_cnt <= (state != S_DRAIN) ? '0 : (dn_ready ? drain_cnt + 1'b1 : drain_cnt);
      if (start_ok) begin
        avg_l     <= cfg_l;
        avg_m     <= cfg_m;
        avg_k     <= cfg_k;
        n_q       <= cfg_n;
        trig_en_q <= cfg_trig_en;
        avg_cnt   <= '0;
        ovf       <= 1'b0;
        cfg_err   <= 1'b0;
        stop_pend <= 1'b0;
      end else if (start_bad) begin
        cfg_err <= 1'b1;
      end
      if (state == S_RUN) begin
        if (round_done)            avg_cnt   <= cnt_inc;
        if (cmd_stop)              stop_pend <= 1'b1;
        if (s_valid && !dn_ready)  ovf       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avg_sched.sv
// Directed bench for avg_sched: expected run results are queued at start and
// checked against each done pulse; timing points are checked inline.
module tb_avg_sched;

  localparam int AW = 10;
  localparam int MW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_l;
  logic [MW-1:0] cfg_m;
  logic [3:0]    cfg_k;
  logic [CW-1:0] cfg_n;
  logic          cfg_trig_en, cmd_start, cmd_stop, trig, s_valid, dn_ready;
  logic          avg_rst, avg_en, avg_vin, busy, done, cfg_err, ovf;
  logic [AW-1:0] avg_l;
  logic [MW-1:0] avg_m;
  logic [3:0]    avg_k;
  logic [CW-1:0] avg_cnt;

  typedef struct {
    int cnt;
    int vins;
    int gap;
  } exp_t;

  exp_t exq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   vin_cnt = 0;
  int   last_vin = 0;

  avg_sched #(.AWIDTH(AW), .MWIDTH(MW), .CWIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .cfg_trig_en(cfg_trig_en), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .trig(trig), .s_valid(s_valid), .dn_ready(dn_ready),
    .avg_rst(avg_rst), .avg_en(avg_en), .avg_vin(avg_vin),
    .avg_l(avg_l), .avg_m(avg_m), .avg_k(avg_k),
    .busy(busy), .done(done), .cfg_err(cfg_err), .ovf(ovf), .avg_cnt(avg_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push_exp(input int c, input int v, input int g);
    exp_t e;
    e.cnt  = c;
    e.vins = v;
    e.gap  = g;
    exq.push_back(e);
  endtask

  task automatic start_run();
    cmd_start = 1'b1;
    nxt();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      nxt();
      mid();
      n++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  // Scoreboard: count forwarded samples per run and check each done pulse.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (avg_vin === 1'b1) begin
      vin_cnt++;
      last_vin = cyc;
    end
    if (done === 1'b1) begin
      chk("done_expected", {31'd0, exq.size() != 0}, 32'd1);
      if (exq.size() != 0) begin
        e = exq.pop_front();
        chk("done_avg_cnt", {16'd0, avg_cnt}, e.cnt);
        chk("done_vins", vin_cnt, e.vins);
        if (e.gap >= 0) chk("done_gap", cyc - last_vin, e.gap);
      end
    end
    if (busy !== 1'b1) vin_cnt = 0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cfg_l = '0; cfg_m = '0; cfg_k = '0; cfg_n = '0; cfg_trig_en = 1'b0;
    cmd_start = 1'b0; cmd_stop = 1'b0; trig = 1'b0; s_valid = 1'b0; dn_ready = 1'b1;

    // Reset values
    nxt(); nxt(); mid();
    chk("rst_avg_rst", {31'd0, avg_rst}, 32'd1);
    chk("rst_avg_en", {31'd0, avg_en}, 32'd0);
    chk("rst_avg_vin", {31'd0, avg_vin}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_avg_cnt", {16'd0, avg_cnt}, 32'd0);
    chk("rst_avg_l", {22'd0, avg_l}, 32'd0);
    nxt(); rst = 1'b1;
    nxt(); mid();
    chk("idle_avg_rst", {31'd0, avg_rst}, 32'd0);
    chk("idle_avg_en", {31'd0, avg_en}, 32'd1);

    // L=4 M=2 K=1 N=3, free-running samples
    nxt();
    cfg_l = 4; cfg_m = 2; cfg_k = 1; cfg_n = 3; cfg_trig_en = 1'b0; s_valid = 1'b1;
    push_exp(3, 24, 4);
    start_run(); mid();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_avg_rst", {31'd0, avg_rst}, 32'd1);
    chk("t1_avg_l", {22'd0, avg_l}, 32'd4);
    chk("t1_avg_m", {24'd0, avg_m}, 32'd2);
    chk("t1_avg_k", {28'd0, avg_k}, 32'd1);
    nxt(); mid();
    chk("t2_avg_rst", {31'd0, avg_rst}, 32'd1);
    nxt(); mid();
    chk("t3_avg_rst", {31'd0, avg_rst}, 32'd0);
    chk("t3_arm_vin", {31'd0, avg_vin}, 32'd0);
    nxt(); mid();
    chk("t4_first_vin", {31'd0, avg_vin}, 32'd1);
    repeat (8) nxt();
    mid();
    chk("cnt_1", {16'd0, avg_cnt}, 32'd1);
    repeat (8) nxt();
    mid();
    chk("cnt_2", {16'd0, avg_cnt}, 32'd2);
    repeat (8) nxt();
    mid();
    chk("cnt_3", {16'd0, avg_cnt}, 32'd3);
    chk("drain_vin", {31'd0, avg_vin}, 32'd0);
    wait_done(10);
    chk("post_busy", {31'd0, busy}, 32'd0);

    // Stop after sample 5, continuous mode: round still completes
    nxt();
    cfg_n = 0;
    push_exp(1, 8, 4);
    start_run();
    repeat (8) nxt();
    cmd_stop = 1'b1;
    nxt();
    cmd_stop = 1'b0;
    mid();
    chk("stop_still_fwd", {31'd0, avg_vin}, 32'd1);
    wait_done(20);
    chk("stop_avg_cnt", {16'd0, avg_cnt}, 32'd1);

    // Stop on the completing sample, and again in DRAIN (ignored)
    nxt();
    cfg_l = 2; cfg_m = 1;
    push_exp(1, 2, 4);
    start_run();
    repeat (4) nxt();
    cmd_stop = 1'b1;
    nxt();
    nxt();
    cmd_stop = 1'b0;
    mid();
    chk("drain_stop_busy", {31'd0, busy}, 32'd1);
    wait_done(10);

    // Hardware trigger gating
    nxt();
    cfg_l = 4; cfg_m = 2; cfg_n = 1; cfg_trig_en = 1'b1;
    push_exp(1, 8, 4);
    start_run();
    repeat (2) nxt();
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("arm_no_vin", {31'd0, avg_vin}, 32'd0);
      nxt();
    end
    trig = 1'b1;
    mid();
    chk("trig_cycle_vin", {31'd0, avg_vin}, 32'd0);
    nxt();
    trig = 1'b0;
    mid();
    chk("after_trig_vin", {31'd0, avg_vin}, 32'd1);
    wait_done(20);

    // trig and stop together in ARM: stop wins, no done
    nxt();
    start_run();
    repeat (2) nxt();
    trig = 1'b1; cmd_stop = 1'b1;
    nxt();
    trig = 1'b0; cmd_stop = 1'b0;
    mid();
    chk("arm_stop_busy", {31'd0, busy}, 32'd0);
    chk("arm_stop_vin", {31'd0, avg_vin}, 32'd0);

    // Rejected start, then an accepted start clears cfg_err
    nxt();
    cfg_m = 0; cfg_trig_en = 1'b0;
    start_run(); mid();
    chk("err_set", {31'd0, cfg_err}, 32'd1);
    chk("err_busy", {31'd0, busy}, 32'd0);
    nxt();
    cfg_l = 4; cfg_m = 1; cfg_n = 1;
    push_exp(1, 4, 4);
    start_run(); mid();
    chk("err_clear", {31'd0, cfg_err}, 32'd0);
    chk("err_start_busy", {31'd0, busy}, 32'd1);

    // dn_ready low for 2 cycles in RUN
    nxt(); nxt(); nxt(); mid();
    chk("bp_first_vin", {31'd0, avg_vin}, 32'd1);
    nxt();
    dn_ready = 1'b0;
    mid();
    chk("bp_vin0", {31'd0, avg_vin}, 32'd0);
    chk("bp_en0", {31'd0, avg_en}, 32'd0);
    nxt(); mid();
    chk("bp_en1", {31'd0, avg_en}, 32'd0);
    chk("bp_ovf", {31'd0, ovf}, 32'd1);
    chk("bp_lcnt_a", {22'd0, dut.u_pos.l_cnt}, 32'd1);
    nxt();
    dn_ready = 1'b1;
    mid();
    chk("bp_lcnt_b", {22'd0, dut.u_pos.l_cnt}, 32'd1);
    chk("bp_resume_vin", {31'd0, avg_vin}, 32'd1);
    wait_done(20);
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Shadow rewrite and ignored start while busy, then reset mid-run
    nxt();
    cfg_l = 4; cfg_m = 2; cfg_n = 0;
    start_run(); mid();
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    repeat (5) nxt();
    cfg_l = 7; cmd_start = 1'b1;
    nxt();
    cmd_start = 1'b0;
    mid();
    chk("shadow_avg_l", {22'd0, avg_l}, 32'd4);
    chk("busy_start_ign", {31'd0, busy}, 32'd1);
    nxt();
    rst = 1'b0;
    nxt();
    rst = 1'b1;
    mid();
    chk("mrst_avg_rst", {31'd0, avg_rst}, 32'd1);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_avg_l", {22'd0, avg_l}, 32'd0);
    chk("mrst_avg_vin", {31'd0, avg_vin}, 32'd0);
    chk("mrst_avg_en", {31'd0, avg_en}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    nxt(); nxt();
    cfg_m = 1; cfg_n = 1;
    push_exp(1, 7, 4);
    start_run(); mid();
    chk("new_avg_l", {22'd0, avg_l}, 32'd7);
    wait_done(30);

    nxt(); mid();
    chk("queue_empty", exq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
